// File: rtl/compare_32b.sv
// 32-bit magnitude comparator: eight 4-bit slice compares merged MSB-first, one register stage.
// Define COMPARE_32B_SIGNED_EN to add the signed_mode port for two's-complement compares.
module compare_32b (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] A,
  input  logic [31:0] B,
`ifdef COMPARE_32B_SIGNED_EN
  input  logic        signed_mode,
`endif
  output logic        A_gt_B,
  output logic        A_lt_B,
  output logic        A_eq_B,
  output logic        out_valid
);

  logic        sign_flip;
  logic [31:0] a_cmp;
  logic [31:0] b_cmp;
  logic [7:0]  slice_gt;
  logic [7:0]  slice_eq;
  logic [7:0]  slice_hit;
  logic [8:0]  eq_above;
  logic        gt_d, lt_d, eq_d;
  logic        gt_p1_q, lt_p1_q, eq_p1_q;
  logic        vld_p1_q;

`ifdef COMPARE_32B_SIGNED_EN
  assign sign_flip = signed_mode;
`else
  assign sign_flip = 1'b0;
`endif

  // Inverting both sign bits maps two's-complement order onto unsigned order.
  assign a_cmp = {A[31] ^ sign_flip, A[30:0]};
  assign b_cmp = {B[31] ^ sign_flip, B[30:0]};

  assign eq_above[8] = 1'b1;

  genvar i;
  for (i = 0; i < 8; i++) begin : g_slice
    assign slice_gt[i]  = a_cmp[4*i +: 4] > b_cmp[4*i +: 4];
    assign slice_eq[i]  = a_cmp[4*i +: 4] == b_cmp[4*i +: 4];
    assign eq_above[i]  = eq_above[i+1] & slice_eq[i];
    assign slice_hit[i] = eq_above[i+1] & slice_gt[i];
  end

  assign gt_d = |slice_hit;
  assign eq_d = eq_above[0];
  assign lt_d = ~gt_d & ~eq_d;

  // Stage p0 -> p1: flags captured on accepted input, held otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gt_p1_q  <= 1'b0;
      lt_p1_q  <= 1'b0;
      eq_p1_q  <= 1'b0;
      vld_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= in_valid;
      if (in_valid) begin
        gt_p1_q <= gt_d;
        lt_p1_q <= lt_d;
        eq_p1_q <= eq_d;
      end
    end
  end

  assign A_gt_B    = gt_p1_q;
  assign A_lt_B    = lt_p1_q;
  assign A_eq_B    = eq_p1_q;
  assign out_valid = vld_p1_q;

endmodule

// File: tb/tb_compare_32b.sv
// Scoreboard bench for compare_32b: driver pushes model results, monitor pops on out_valid.
module tb_compare_32b;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] A;
  logic [31:0] B;
  logic        A_gt_B, A_lt_B, A_eq_B, out_valid;
`ifdef COMPARE_32B_SIGNED_EN
  logic        signed_mode;
`endif

  always #5 clk = ~clk;

  compare_32b dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .A           (A),
    .B           (B),
`ifdef COMPARE_32B_SIGNED_EN
    .signed_mode (signed_mode),
`endif
    .A_gt_B      (A_gt_B),
    .A_lt_B      (A_lt_B),
    .A_eq_B      (A_eq_B),
    .out_valid   (out_valid)
  );

  logic [2:0] exp_q[$];
  int         n_vec  = 0;
  int         n_fail = 0;

  // Expected {gt, lt, eq} from plain integer ordering.
  function automatic logic [2:0] model(input logic [31:0] a, input logic [31:0] b, input logic sm);
    int sa, sb;
    if (sm) begin
      sa = $signed(a);
      sb = $signed(b);
      return {sa > sb, sa < sb, sa == sb};
    end
    return {a > b, a < b, a == b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic v, input logic r,
                       input logic sm);
    logic eff_sm;
    @(posedge clk);
    #1;
`ifdef COMPARE_32B_SIGNED_EN
    signed_mode = sm;
    eff_sm      = sm;
`else
    eff_sm      = 1'b0;
`endif
    A        = a;
    B        = b;
    in_valid = v;
    rst_n    = r;
    if (v && r) exp_q.push_back(model(a, b, eff_sm));
  endtask

  // Monitor: samples what was driven at each edge, checks the registered result half a cycle later.
  logic       r_s, v_s;
  logic [2:0] held = 3'b000;
  logic [2:0] got, e;
  initial begin
    forever begin
      @(posedge clk);
      r_s = rst_n;
      v_s = in_valid;
      @(negedge clk);
      got = {A_gt_B, A_lt_B, A_eq_B};
      if (!r_s) begin
        chk("reset_flags", {29'b0, got}, 32'd0);
        chk("reset_vld", {31'b0, out_valid}, 32'd0);
        held = 3'b000;
      end else begin
        chk("out_valid", {31'b0, out_valid}, {31'b0, v_s});
        if (out_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_output: got flags %b with empty scoreboard at %0t", got, $time);
          end else begin
            e = exp_q.pop_front();
            chk("flags", {29'b0, got}, {29'b0, e});
            held = e;
          end
          chk("onehot", $countones(got), 32'd1);
        end else begin
          chk("hold", {29'b0, got}, {29'b0, held});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation ran past %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, b;
    int          k;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    A        = 32'd0;
    B        = 32'd0;
`ifdef COMPARE_32B_SIGNED_EN
    signed_mode = 1'b0;
`endif
    apply(32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    apply(32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

    apply(32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    apply(32'd1, 32'd0, 1'b1, 1'b1, 1'b0);
    apply(32'd1, 32'd1, 1'b1, 1'b1, 1'b0);
    apply(32'd0, 32'd1, 1'b1, 1'b1, 1'b0);
    apply(32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1, 1'b0);
    apply(32'd0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
    apply(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    apply(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1);
    apply(32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1, 1'b1);
    apply(32'h1234_5678, 32'h1234_5679, 1'b1, 1'b1, 1'b0);

    for (int s = 0; s < 32; s++) begin
      a = $urandom;
      b = a ^ (32'd1 << s);
      apply(a, b, 1'b1, 1'b1, 1'b0);
      apply(b, a, 1'b1, 1'b1, 1'b0);
      apply(a, b, 1'b1, 1'b1, 1'b1);
    end

    // Hold after a gt result, then reset mid-stream.
    apply(32'd5, 32'd3, 1'b1, 1'b1, 1'b0);
    apply(32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    apply(32'd9, 32'd1, 1'b0, 1'b1, 1'b0);
    apply(32'd2, 32'd1, 1'b1, 1'b1, 1'b0);
    apply(32'd1, 32'd2, 1'b1, 1'b0, 1'b0);
    apply(32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    apply(32'd3, 32'd7, 1'b1, 1'b1, 1'b0);

    for (int n = 0; n < 10000; n++) begin
      a = $urandom;
      k = $urandom_range(0, 3);
      if (k == 0)      b = a;
      else if (k == 1) b = a ^ (32'd1 << $urandom_range(0, 31));
      else             b = $urandom;
      apply(a, b, $urandom_range(0, 3) != 0, $urandom_range(0, 99) != 0,
            1'($urandom_range(0, 1)));
    end

    apply(32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    apply(32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
